// File: rtl/x_test_loader.sv
// Pixel-stream loader for the stage-1 HWF SVM classifier: packs a frame
// into x_test, runs the classifier for a fixed window, returns y_class.
//
// Ports:
//   clk, rst                           clock, async active-high reset
//   pix_valid/pix_data/pix_last/pix_ready  pixel stream handshake
//   x_test                             packed frame, pixel k at [k*W +: W]
//   en, hwf_en                         classifier enables (RUN window)
//   y_class                            classifier decision input
//   result_valid/result_class/frame_err/result_ready  result handshake
module x_test_loader #(
  parameter int XLEN_PIXEL      = 8,
  parameter int NUM_OF_PIXELS   = 784,
  parameter int CLASSIFY_CYCLES = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pix_valid,
  input  logic [XLEN_PIXEL-1:0]               pix_data,
  input  logic                                pix_last,
  output logic                                pix_ready,
  output logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0] x_test,
  output logic                                en,
  output logic                                hwf_en,
  input  logic                                y_class,
  output logic                                result_valid,
  output logic                                result_class,
  output logic                                frame_err,
  input  logic                                result_ready
);

  localparam int CW = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
  localparam int RW = (CLASSIFY_CYCLES > 1) ? $clog2(CLASSIFY_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OF_PIXELS - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(CLASSIFY_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    REPORT
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] count;
  logic [RW-1:0] run_cnt;
  logic          accept;
  logic          at_last;
  logic          frame_end;
  logic          run_done;
  logic          handshake;

  always_comb begin
    state_d      = state;
    pix_ready    = 1'b0;
    en           = 1'b0;
    hwf_en       = 1'b0;
    result_valid = 1'b0;
    at_last      = (count == LAST_IDX);
    accept       = (state == LOAD) && pix_valid;
    frame_end    = accept && (pix_last || at_last);
    run_done     = (state == RUN) && (run_cnt == RUN_LAST);
    handshake    = (state == REPORT) && result_ready;
    unique case (state)
      LOAD: begin
        pix_ready = 1'b1;
        if (frame_end) state_d = RUN;
      end
      RUN: begin
        en     = 1'b1;
        hwf_en = 1'b1;
        if (run_done) state_d = REPORT;
      end
      REPORT: begin
        result_valid = 1'b1;
        if (handshake) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      count        <= '0;
      run_cnt      <= '0;
      x_test       <= '0;
      result_class <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        x_test[count*XLEN_PIXEL +: XLEN_PIXEL] <= pix_data;
        count <= frame_end ? '0 : count + CW'(1);
        // error when last flag and full count disagree
        if (frame_end) frame_err <= pix_last ^ at_last;
      end
      if (state == RUN) begin
        run_cnt <= run_done ? '0 : run_cnt + RW'(1);
        if (run_done) result_class <= y_class;
      end
      if (handshake) begin
        x_test    <= '0;
        count     <= '0;
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_x_test_loader.sv
// Self-checking bench for x_test_loader: randomized frames checked
// against a byte-array model of the loaded image and result.
module tb_x_test_loader;
  localparam int W = 8;
  localparam int N = 784;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         pix_valid;
  logic [W-1:0] pix_data;
  logic         pix_last;
  logic         pix_ready;
  logic [N*W-1:0] x_test;
  logic         en;
  logic         hwf_en;
  logic         y_class;
  logic         result_valid;
  logic         result_class;
  logic         frame_err;
  logic         result_ready;

  always #5 clk = ~clk;

  x_test_loader #(
    .XLEN_PIXEL(W),
    .NUM_OF_PIXELS(N),
    .CLASSIFY_CYCLES(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_last(pix_last),
    .pix_ready(pix_ready),
    .x_test(x_test),
    .en(en),
    .hwf_en(hwf_en),
    .y_class(y_class),
    .result_valid(result_valid),
    .result_class(result_class),
    .frame_err(frame_err),
    .result_ready(result_ready)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] beat_data[800];
  logic [7:0] exp_x[N];
  bit exp_err;
  bit exp_cls;
  bit rr_tied = 0;

  function automatic logic [N*W-1:0] exp_vec();
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = exp_x[k];
    return v;
  endfunction

  function automatic int first_diff(input logic [N*W-1:0] a,
                                    input logic [N*W-1:0] b);
    for (int k = 0; k < N; k++)
      if (a[k*W +: W] !== b[k*W +: W]) return k;
    return -1;
  endfunction

  // Streams beats; the model accepts every valid beat while loading and
  // ends the frame on pix_last or the N-th pixel.
  task automatic drive_frame(input int nbeats, input int last_at,
                             input int gap_pct, input int abort_after,
                             output int sent);
    int acc;
    int cyc;
    bit done;
    logic [N*W-1:0] ev;
    int d;
    acc = 0;
    cyc = 0;
    done = 0;
    for (int k = 0; k < N; k++) exp_x[k] = 8'h00;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      pix_valid = (acc < nbeats) && ($urandom_range(99) >= gap_pct);
      pix_data  = (acc < nbeats) ? beat_data[acc] : 8'h00;
      pix_last  = (acc == last_at);
      #1;
      n_total++;
      if (pix_ready !== 1'b1)
        $display("FAIL load_ready: got %b want 1 (beat %0d)", pix_ready, acc);
      else n_pass++;
      if (pix_valid) begin
        exp_x[acc] = pix_data;
        if (pix_last || acc == N - 1) begin
          exp_err = pix_last ? (acc != N - 1) : 1'b1;
          done = 1;
        end
        acc++;
      end
      cyc++;
      if (abort_after > 0 && acc == abort_after) break;
    end
    if (!done && abort_after == 0) begin
      n_total++;
      $display("FAIL frame_timeout: got %0d beats want frame end", acc);
    end
    @(posedge clk);
    #1;
    pix_valid = 0;
    pix_last  = 0;
    if (abort_after > 0) begin
      ev = exp_vec();
      d = first_diff(x_test, ev);
      n_total++;
      if (d >= 0)
        $display("FAIL partial_x byte %0d: got %h want %h",
                 d, x_test[d*W +: W], ev[d*W +: W]);
      else n_pass++;
    end
    sent = acc;
  endtask

  // RUN window; extra beats keep arriving and must be refused.
  task automatic run_phase(input int extra, input int stop_after,
                           input bit ycls_one);
    logic [N*W-1:0] ev;
    int d;
    ev = exp_vec();
    for (int j = 1; j <= C; j++) begin
      @(negedge clk);
      pix_valid = (j <= extra);
      pix_last  = 0;
      pix_data  = 8'($urandom);
      y_class   = ycls_one ? 1'b1 : 1'($urandom_range(1));
      #1;
      n_total++;
      if ({en, hwf_en, pix_ready, result_valid} !== 4'b1100)
        $display("FAIL run_ctl cyc %0d: got %b want 1100", j,
                 {en, hwf_en, pix_ready, result_valid});
      else n_pass++;
      if (j == 1 || j == C) begin
        d = first_diff(x_test, ev);
        n_total++;
        if (d >= 0)
          $display("FAIL x_test byte %0d: got %h want %h",
                   d, x_test[d*W +: W], ev[d*W +: W]);
        else n_pass++;
      end
      if (j == C) exp_cls = y_class;
      if (j == stop_after) break;
    end
    pix_valid = 0;
  endtask

  task automatic report_phase(input int hold);
    for (int j = 0; j <= hold; j++) begin
      @(negedge clk);
      result_ready = rr_tied || (j == hold);
      y_class = ~y_class;
      #1;
      n_total++;
      if ({result_valid, result_class, frame_err, en, pix_ready} !==
          {1'b1, exp_cls, exp_err, 1'b0, 1'b0})
        $display("FAIL report cyc %0d: got v%b c%b e%b en%b r%b want v1 c%b e%b en0 r0",
                 j, result_valid, result_class, frame_err, en, pix_ready,
                 exp_cls, exp_err);
      else n_pass++;
    end
    @(negedge clk);
    result_ready = rr_tied;
    #1;
    n_total++;
    if ({result_valid, pix_ready, frame_err} !== 3'b010 || x_test !== '0)
      $display("FAIL after_hs: got v%b r%b e%b xz%b want v0 r1 e0 xz1",
               result_valid, pix_ready, frame_err, (x_test == '0));
    else n_pass++;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1;
    #1;
    n_total++;
    if ({en, hwf_en, result_valid, result_class, frame_err} !== 5'b0 ||
        x_test !== '0)
      $display("FAIL %s_in_reset: got en%b h%b v%b c%b e%b xz%b want all 0, xz1",
               tag, en, hwf_en, result_valid, result_class, frame_err,
               (x_test == '0));
    else n_pass++;
    @(negedge clk);
    rst = 0;
    #1;
    n_total++;
    if ({pix_ready, en, result_valid} !== 3'b100)
      $display("FAIL %s_release: got r%b en%b v%b want r1 en0 v0",
               tag, pix_ready, en, result_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    apply_reset("por");
  endtask

  task automatic test_nominal();
    int s;
    for (int k = 0; k < 800; k++) beat_data[k] = 8'(k % 256);
    drive_frame(N, N - 1, 0, 0, s);
    run_phase(0, 0, 1'b1);
    n_total++;
    if (exp_cls !== 1'b1 || exp_err !== 1'b0)
      $display("FAIL nominal_model: got c%b e%b want c1 e0", exp_cls, exp_err);
    else n_pass++;
    report_phase(0);
  endtask

  task automatic test_early_last();
    int s;
    for (int k = 0; k < 800; k++) beat_data[k] = 8'hAA;
    drive_frame(10, 9, 0, 0, s);
    run_phase(0, 0, 1'b0);
    report_phase(2);
  endtask

  task automatic test_missing_last();
    int s;
    for (int k = 0; k < 800; k++) beat_data[k] = 8'($urandom);
    drive_frame(790, -1, 0, 0, s);
    n_total++;
    if (s !== N)
      $display("FAIL missing_last_len: got %0d want %0d", s, N);
    else n_pass++;
    run_phase(790 - s, 0, 1'b0);
    report_phase(1);
  endtask

  task automatic test_backpressure();
    int s;
    for (int k = 0; k < 800; k++) beat_data[k] = 8'($urandom);
    drive_frame(N, N - 1, 30, 0, s);
    run_phase(0, 0, 1'b0);
    report_phase(5);
  endtask

  task automatic test_reset_mid();
    int s;
    for (int k = 0; k < 800; k++) beat_data[k] = 8'($urandom | 1);
    drive_frame(N, N - 1, 0, 300, s);
    apply_reset("mid_load");
    drive_frame(50, 49, 0, 0, s);
    run_phase(0, 5, 1'b0);
    apply_reset("mid_run");
    for (int k = 0; k < 800; k++) beat_data[k] = 8'($urandom);
    drive_frame(N, N - 1, 10, 0, s);
    run_phase(0, 0, 1'b0);
    report_phase(0);
  endtask

  task automatic test_back_to_back();
    int s;
    rr_tied = 1;
    result_ready = 1;
    for (int k = 0; k < 800; k++) beat_data[k] = 8'($urandom | 8'h80);
    drive_frame(N, N - 1, 0, 0, s);
    run_phase(0, 0, 1'b0);
    report_phase(0);
    for (int k = 0; k < 800; k++) beat_data[k] = 8'($urandom & 8'h7F);
    drive_frame(100, 99, 0, 0, s);
    run_phase(0, 0, 1'b0);
    report_phase(0);
    rr_tied = 0;
    result_ready = 0;
  endtask

  initial begin
    rst = 1;
    pix_valid = 0;
    pix_data = '0;
    pix_last = 0;
    y_class = 0;
    result_ready = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_nominal();
    test_early_last();
    test_missing_last();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
